// File: rtl/cpu_pkg.sv
// Shared CPU types: branch condition encoding and architectural NZVC flag layout.
package cpu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

endpackage

// File: rtl/flag_cond_unit_cond_eval.sv
// Combinational LEGv8 condition evaluator; shared with the branch-predictor check.
module cond_eval
  import cpu_pkg::*;
(
  input  cond_e  cond,
  input  flags_t flags,
  output logic   cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_EQ: cond_true = flags.z;
      COND_NE: cond_true = !flags.z;
      COND_HS: cond_true = flags.c;
      COND_LO: cond_true = !flags.c;
      COND_MI: cond_true = flags.n;
      COND_PL: cond_true = !flags.n;
      COND_VS: cond_true = flags.v;
      COND_VC: cond_true = !flags.v;
      COND_HI: cond_true = flags.c && !flags.z;
      COND_LS: cond_true = !flags.c || flags.z;
      COND_GE: cond_true = (flags.n == flags.v);
      COND_LT: cond_true = (flags.n != flags.v);
      COND_GT: cond_true = !flags.z && (flags.n == flags.v);
      COND_LE: cond_true = flags.z || (flags.n != flags.v);
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// NZVC flag register with EX->ID forwarding and registered B.cond/CBZ/CBNZ decision.
module flag_cond_unit
  import cpu_pkg::*;
#(
  parameter int COND_W = 4,
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic              ex_set_flags,
  input  logic              alu_negative,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              alu_carry_out,
  input  logic              id_valid,
  input  logic              id_is_bcond,
  input  logic              id_is_cbz,
  input  logic              id_is_cbnz,
  input  logic [COND_W-1:0] id_cond,
  input  logic              id_reg_zero,
  input  logic              stall,
  input  logic              flush,
  output logic [FLAG_W-1:0] flags_q,
  output logic              br_valid,
  output logic              br_taken
);

  flags_t            alu_flags;
  flags_t            eff_flags;
  cond_e             id_cond_e;
  logic              ex_writes;
  logic              cond_true;
  logic              is_br;
  logic              take;
  logic [FLAG_W-1:0] flags_d;
  logic              br_valid_d, br_valid_q;
  logic              br_taken_d, br_taken_q;

  always_comb begin
    alu_flags.n = alu_negative;
    alu_flags.z = alu_zero;
    alu_flags.v = alu_overflow;
    alu_flags.c = alu_carry_out;
    ex_writes   = ex_valid && ex_set_flags;
    // Fresh EX flags bypass the register so a B.cond right behind a setter needs no bubble.
    eff_flags   = ex_writes ? alu_flags : flags_t'(flags_q);
    id_cond_e   = cond_e'(id_cond);
  end

  cond_eval u_cond_eval (
    .cond      (id_cond_e),
    .flags     (eff_flags),
    .cond_true (cond_true)
  );

  always_comb begin
    is_br = id_valid && (id_is_bcond || id_is_cbz || id_is_cbnz);
    take  = 1'b0;
    if (id_is_bcond)     take = cond_true;
    else if (id_is_cbz)  take = id_reg_zero;
    else if (id_is_cbnz) take = !id_reg_zero;
  end

  always_comb begin
    flags_d    = flags_q;
    br_valid_d = br_valid_q;
    br_taken_d = br_taken_q;
    if (ex_writes && !stall) flags_d = FLAG_W'(alu_flags);
    if (flush) begin
      br_valid_d = 1'b0;
      br_taken_d = 1'b0;
    end else if (!stall) begin
      br_valid_d = is_br;
      br_taken_d = is_br && take;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flags_q    <= '0;
      br_valid_q <= 1'b0;
      br_taken_q <= 1'b0;
    end else begin
      flags_q    <= flags_d;
      br_valid_q <= br_valid_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign br_valid = br_valid_q;
  assign br_taken = br_taken_q;

  always_ff @(posedge clk) begin
    if (reset_n && id_valid) assert ($onehot0({id_is_bcond, id_is_cbz, id_is_cbnz}));
    assert (!(br_taken_q && !br_valid_q));
  end

endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed self-checking bench for flag_cond_unit.
module tb_flag_cond_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ex_valid, ex_set_flags;
  logic       alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic       id_valid, id_is_bcond, id_is_cbz, id_is_cbnz;
  logic [3:0] id_cond;
  logic       id_reg_zero, stall, flush;
  logic [3:0] flags_q;
  logic       br_valid, br_taken;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  flag_cond_unit #(.COND_W(4), .FLAG_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
    .id_valid(id_valid), .id_is_bcond(id_is_bcond), .id_is_cbz(id_is_cbz),
    .id_is_cbnz(id_is_cbnz), .id_cond(id_cond), .id_reg_zero(id_reg_zero),
    .stall(stall), .flush(flush),
    .flags_q(flags_q), .br_valid(br_valid), .br_taken(br_taken)
  );

  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy;
    {n, z, v, cy} = f;
    case (c)
      4'h0: return z;          4'h1: return !z;
      4'h2: return cy;         4'h3: return !cy;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return cy & !z;    4'h9: return !cy | z;
      4'hA: return n == v;     4'hB: return n != v;
      4'hC: return !z & (n == v);
      4'hD: return z | (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; ex_set_flags = 0;
    {alu_negative, alu_zero, alu_overflow, alu_carry_out} = 4'b0000;
    id_valid = 0; id_is_bcond = 0; id_is_cbz = 0; id_is_cbnz = 0;
    id_cond = 4'h0; id_reg_zero = 0; stall = 0; flush = 0;
  endtask

  task automatic drive_ex(input logic [3:0] f);
    ex_valid = 1; ex_set_flags = 1;
    {alu_negative, alu_zero, alu_overflow, alu_carry_out} = f;
  endtask

  task automatic drive_bcond(input logic [3:0] c);
    id_valid = 1; id_is_bcond = 1; id_is_cbz = 0; id_is_cbnz = 0; id_cond = c;
  endtask

  task automatic test_reset();
    reset_n = 0;
    ex_valid = 1; ex_set_flags = 1;
    {alu_negative, alu_zero, alu_overflow, alu_carry_out} = 4'b1111;
    id_valid = 1; id_is_bcond = 1; id_is_cbz = 1; id_is_cbnz = 1;
    id_cond = 4'hE; id_reg_zero = 1; stall = 1; flush = 1;
    tick(); tick();
    n_cmp++;
    if ({flags_q, br_valid, br_taken} !== 6'b0000_00) begin
      n_err++;
      $display("FAIL reset: got flags=%b v=%b t=%b, want 0000 0 0", flags_q, br_valid, br_taken);
    end
    idle();
    reset_n = 1;
  endtask

  task automatic test_forwarding();
    idle(); drive_ex(4'b0101); drive_bcond(4'h0);
    tick();
    n_cmp++;
    if ({flags_q, br_valid, br_taken} !== 6'b0101_11) begin
      n_err++;
      $display("FAIL fwd_beq: got flags=%b v=%b t=%b, want 0101 1 1", flags_q, br_valid, br_taken);
    end
    idle(); drive_bcond(4'h3);
    tick();
    n_cmp++;
    if ({flags_q, br_valid, br_taken} !== 6'b0101_10) begin
      n_err++;
      $display("FAIL fwd_blo: got flags=%b v=%b t=%b, want 0101 1 0", flags_q, br_valid, br_taken);
    end
  endtask

  task automatic test_signed();
    logic [3:0] conds [4];
    logic [3:0] fl    [4];
    logic       exp   [4];
    conds = '{4'hB, 4'hA, 4'hC, 4'hD};
    fl    = '{4'b1000, 4'b1000, 4'b1000, 4'b1100};
    exp   = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      idle(); drive_ex(fl[i]); tick();
      idle(); drive_bcond(conds[i]); tick();
      n_cmp++;
      if ({br_valid, br_taken} !== {1'b1, exp[i]}) begin
        n_err++;
        $display("FAIL signed[%0d] cond=%h flags=%b: got v=%b t=%b, want 1 %b",
                 i, conds[i], fl[i], br_valid, br_taken, exp[i]);
      end
    end
  endtask

  task automatic test_cond_sweep();
    for (int f = 0; f < 16; f++) begin
      idle(); drive_ex(4'(f)); tick();
      n_cmp++;
      if (flags_q !== 4'(f)) begin
        n_err++;
        $display("FAIL sweep_flags: got %b, want %b", flags_q, 4'(f));
      end
      for (int c = 0; c < 16; c++) begin
        idle(); drive_bcond(4'(c)); tick();
        n_cmp++;
        if ({br_valid, br_taken} !== {1'b1, cond_ref(4'(c), 4'(f))}) begin
          n_err++;
          $display("FAIL sweep cond=%h flags=%b: got v=%b t=%b, want 1 %b",
                   c, f, br_valid, br_taken, cond_ref(4'(c), 4'(f)));
        end
      end
    end
  endtask

  task automatic test_cbz_cbnz();
    logic [2:0] exp;
    idle(); drive_ex(4'b1111); tick();
    for (int i = 0; i < 4; i++) begin
      idle();
      id_valid = 1;
      id_is_cbz = (i % 2 == 0);
      id_is_cbnz = (i % 2 == 1);
      id_reg_zero = (i < 2);
      tick();
      exp = {1'b1, (i == 0 || i == 3), 1'b1};
      n_cmp++;
      if ({br_valid, br_taken, flags_q == 4'b1111} !== exp) begin
        n_err++;
        $display("FAIL cbz_cbnz[%0d]: got v=%b t=%b flags=%b, want v=1 t=%b flags=1111",
                 i, br_valid, br_taken, flags_q, exp[1]);
      end
    end
  endtask

  task automatic test_stall_flush();
    idle(); id_valid = 1; id_is_cbnz = 1; id_reg_zero = 0; tick();
    idle(); drive_ex(4'b0010); stall = 1;
    id_valid = 1; id_is_cbz = 1; id_reg_zero = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({flags_q, br_valid, br_taken} !== 6'b1111_11) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got flags=%b v=%b t=%b, want 1111 1 1",
                 i, flags_q, br_valid, br_taken);
      end
    end
    stall = 0;
    tick();
    n_cmp++;
    if ({flags_q, br_valid, br_taken} !== 6'b0010_10) begin
      n_err++;
      $display("FAIL stall_release: got flags=%b v=%b t=%b, want 0010 1 0", flags_q, br_valid, br_taken);
    end
    idle(); {alu_negative, alu_zero, alu_overflow, alu_carry_out} = 4'b1001; tick();
    n_cmp++;
    if (flags_q !== 4'b0010) begin
      n_err++;
      $display("FAIL stall_once: got flags=%b, want 0010", flags_q);
    end
    idle(); drive_bcond(4'hE); tick();
    idle(); drive_bcond(4'hE); drive_ex(4'b0100); stall = 1; flush = 1; tick();
    n_cmp++;
    if ({flags_q, br_valid, br_taken} !== 6'b0010_00) begin
      n_err++;
      $display("FAIL flush_over_stall: got flags=%b v=%b t=%b, want 0010 0 0", flags_q, br_valid, br_taken);
    end
    stall = 0; tick();
    n_cmp++;
    if ({flags_q, br_valid, br_taken} !== 6'b0100_00) begin
      n_err++;
      $display("FAIL flush_commit: got flags=%b v=%b t=%b, want 0100 0 0", flags_q, br_valid, br_taken);
    end
  endtask

  task automatic test_reset_midop();
    idle(); drive_ex(4'b1010); drive_bcond(4'hE); tick();
    n_cmp++;
    if ({flags_q, br_valid, br_taken} !== 6'b1010_11) begin
      n_err++;
      $display("FAIL midop_setup: got flags=%b v=%b t=%b, want 1010 1 1", flags_q, br_valid, br_taken);
    end
    reset_n = 0; tick();
    n_cmp++;
    if ({flags_q, br_valid, br_taken} !== 6'b0000_00) begin
      n_err++;
      $display("FAIL midop_reset: got flags=%b v=%b t=%b, want 0000 0 0", flags_q, br_valid, br_taken);
    end
    reset_n = 1;
    idle(); drive_ex(4'b0001); id_valid = 1; id_is_cbz = 1; id_reg_zero = 1; tick();
    n_cmp++;
    if ({flags_q, br_valid, br_taken} !== 6'b0001_11) begin
      n_err++;
      $display("FAIL midop_resume: got flags=%b v=%b t=%b, want 0001 1 1", flags_q, br_valid, br_taken);
    end
  endtask

  initial begin
    idle();
    reset_n = 0;
    #1;
    test_reset();
    test_forwarding();
    test_signed();
    test_cond_sweep();
    test_cbz_cbnz();
    test_stall_flush();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/flag_cond_unit.md
Name: flag_cond_unit

Overview:
- Consumer end of the ALU flag interface. The ALU datapath (bitwise, add/sub) produces negative/zero/overflow/carry flags; this block receives them.
- Captures the flags into the architectural NZVC register on flag-setting instructions.
- Forwards fresh flags from EX to a conditional branch in ID.
- Evaluates B.cond / CBZ / CBNZ and delivers a registered branch decision to the pipelined CPU's fetch/PC logic.

Parameters:
- COND_W, 4, width of the branch condition field (LEGv8 cond encoding).
- FLAG_W, 4, number of architectural flags (N,Z,V,C order, MSB = N).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- ex_valid  input  1  EX stage holds a live instruction.
- ex_set_flags  input  1  EX instruction writes flags (ADDS/SUBS/ANDS class).
- alu_negative  input  1  ALU N flag for EX result.
- alu_zero  input  1  ALU Z flag for EX result.
- alu_overflow  input  1  ALU V flag.
- alu_carry_out  input  1  ALU C flag.
- id_valid  input  1  ID stage holds a live instruction.
- id_is_bcond  input  1  ID instruction is B.cond.
- id_is_cbz  input  1  ID instruction is CBZ.
- id_is_cbnz  input  1  ID instruction is CBNZ.
- id_cond  input  COND_W  condition code of B.cond.
- id_reg_zero  input  1  tested register equals 0 (from the register-compare block).
- stall  input  1  pipeline hold; no stage advances.
- flush  input  1  kill the ID-stage instruction.
- flags_q  output  FLAG_W  architectural NZVC register.
- br_valid  output  1  registered: a branch decision is presented this cycle.
- br_taken  output  1  registered: that branch is taken.

Behaviour:
- Reset (reset_n=0 at a rising edge): flags_q=4'b0000, br_valid=0, br_taken=0. Reset overrides stall, flush and all writes.
- Flag commit: at the edge, if ex_valid & ex_set_flags & !stall, flags_q <= {alu_negative, alu_zero, alu_overflow, alu_carry_out}. Otherwise flags_q holds.
- Forwarding, combinational:
  - eff_flags = new ALU flags when ex_valid & ex_set_flags.
  - Otherwise eff_flags = flags_q.
  - A B.cond directly behind a flag setter therefore sees the fresh flags with zero bubbles.
- Condition decode on eff_flags {N,Z,V,C}:
  - 0 EQ: Z. 1 NE: !Z. 2 HS: C. 3 LO: !C.
  - 4 MI: N. 5 PL: !N. 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z.
  - A GE: N==V. B LT: N!=V. C GT: !Z&(N==V). D LE: Z|(N!=V).
  - E AL: 1. F NV: 1.
- Decision:
  - is_br = id_valid & (id_is_bcond | id_is_cbz | id_is_cbnz).
  - take = (bcond & cond_true) | (cbz & id_reg_zero) | (cbnz & !id_reg_zero).
  - More than one of the is_* bits set is illegal; assertion required. Priority in RTL is bcond > cbz > cbnz.
- Decision register, one-cycle latency:
  - flush=1: br_valid <= 0, br_taken <= 0. Flush beats stall.
  - stall=1 (no flush): br_valid and br_taken hold.
  - Otherwise: br_valid <= is_br, br_taken <= is_br & take.
- br_taken is never 1 while br_valid is 0.
- Simultaneous events:
  - Flag write and B.cond in the same cycle: the branch uses the forwarded value, and flags_q updates at the same edge.
  - stall with ex_set_flags: no commit; the write occurs in the cycle the stall drops, so flags are written exactly once.
  - flush does not block the EX flag commit, because EX is older than ID.
- Reset mid-operation: a pending decision is discarded and flags are cleared; no partial state survives.
- No X propagation: ALU flags are ignored when ex_valid=0.

Decomposition:
- Shared package cpu_pkg holds:
  - cond_e enum (EQ..NV, 4-bit);
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_V=1, FLAG_C=0;
  - flags_t packed struct.
- One natural sub-module: cond_eval. It is purely combinational (cond_e + flags_t -> cond_true), so the branch-predictor check can reuse it.

Test Plan:
- Reset: drive reset_n=0 for 2 cycles with all inputs active -> flags_q=0000, br_valid=0, br_taken=0.
- Forwarding:
  - EX SUBS with N=0 Z=1 V=0 C=1; ID B.EQ (cond 0) in the same cycle.
  - Next edge: br_valid=1, br_taken=1, flags_q=0101.
  - Next instruction B.LO (cond 3) -> br_taken=0.
- Signed compare sweep: flags_q=N1,V0 -> B.LT taken, B.GE not, B.GT not. With Z=1, B.LE taken. Cover all 16 codes against all 16 flag patterns (256 checks against the reference model).
- CBZ/CBNZ:
  - id_reg_zero=1 -> CBZ taken, CBNZ not.
  - id_reg_zero=0 -> inverse.
  - Flags are irrelevant: set flags_q=1111 and confirm.
- Stall/flush:
  - SUBS held 3 cycles by stall -> flags_q unchanged until stall drops, then written once.
  - Branch decision held during stall.
  - flush with is_br=1 -> br_valid=0 next edge, even with stall=1.
- Reset mid-op: flags_q=1010 and br_valid=1, assert reset_n=0 for 1 cycle -> all outputs 0 at that edge; normal operation resumes on the next edge.
